flag_branch_resolver: RTL

//  Downstream consumer of the 7-bit flag vector {Sign,Call,Co,Zimm,Ziw2,Ziw1,Col} (bits 6..0).

---
 rtl/flag_branch_resolver.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/flag_branch_resolver.sv
// Conditional-branch resolver: holds registered and sticky flag copies, tracks in-flight ALU ops,
// and resolves branch requests once flags have settled (or a wait timeout expires).
module flag_branch_resolver #(
  parameter int unsigned AW      = 16,
  parameter int unsigned PEND_W  = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          alu_issue,
  input  logic          flag_we,
  input  logic [6:0]    flag_in,
  input  logic          sticky_clr,
  input  logic          br_valid,
  output logic          br_ready,
  input  logic [3:0]    br_cond,
  input  logic [AW-1:0] br_target,
  output logic          res_valid,
  output logic          res_taken,
  output logic          pc_load,
  output logic [AW-1:0] pc_target,
  output logic          flush_req,
  output logic          err_cond,
  output logic          err_timeout,
  output logic [6:0]    flag_q,
  output logic [6:0]    sticky_q
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PEND_W-1:0] PendMax   = {PEND_W{1'b1}};
  localparam logic [TW-1:0]     TimerLast = TW'(TIMEOUT - 1);
  localparam logic [3:0]        CondRsvd  = 4'd15;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResolve
  } state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic [3:0]        cond_q, cond_d;
  logic [AW-1:0]     target_q, target_d;
  logic              tout_q, tout_d;
  logic [6:0]        sticky_d;

  logic              res_valid_q, res_valid_d;
  logic              res_taken_q, res_taken_d;
  logic              err_cond_q, err_cond_d;
  logic              err_timeout_q, err_timeout_d;
  logic [AW-1:0]     pc_target_q, pc_target_d;

  logic [2:0]        flag_idx;
  logic              cond_true;

  // Flag registers are unaffected by flush; clr and we in the same cycle leaves flag_in.
  always_comb begin
    sticky_d = (sticky_clr ? 7'h00 : sticky_q) | (flag_we ? flag_in : 7'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q   <= 7'h00;
      sticky_q <= 7'h00;
    end else begin
      if (flag_we) begin
        flag_q <= flag_in;
      end
      sticky_q <= sticky_d;
    end
  end

  // In-flight ALU op counter: saturating up, flooring down, cleared by flush.
  always_comb begin
    pend_d = pend_q;
    if (flush) begin
      pend_d = '0;
    end else if (alu_issue && !flag_we) begin
      if (pend_q != PendMax) begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (flag_we && !alu_issue) begin
      if (pend_q != '0) begin
        pend_d = pend_q - PEND_W'(1);
      end
    end
  end

  // Condition codes 1..7 test a flag set, 8..14 test a flag clear.
  always_comb begin
    flag_idx  = cond_q[3] ? cond_q[2:0] : (cond_q[2:0] - 3'd1);
    cond_true = 1'b0;
    if (cond_q == 4'd0) begin
      cond_true = 1'b1;
    end else if (cond_q == CondRsvd) begin
      cond_true = 1'b0;
    end else if (!cond_q[3]) begin
      cond_true = flag_q[flag_idx];
    end else begin
      cond_true = !flag_q[flag_idx];
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = '0;
    cond_d        = cond_q;
    target_d      = target_q;
    tout_d        = tout_q;
    res_valid_d   = 1'b0;
    res_taken_d   = 1'b0;
    err_cond_d    = 1'b0;
    err_timeout_d = 1'b0;
    pc_target_d   = pc_target_q;
    br_ready      = (state_q == StIdle);

    unique case (state_q)
      StIdle: begin
        if (br_valid && !flush) begin
          cond_d   = br_cond;
          target_d = br_target;
          tout_d   = 1'b0;
          state_d  = ((pend_q != '0) || alu_issue) ? StWait : StResolve;
        end
      end
      StWait: begin
        if (pend_q == '0) begin
          state_d = StResolve;
        end else if (timer_q == TimerLast) begin
          state_d = StResolve;
          tout_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StResolve: begin
        res_valid_d   = 1'b1;
        res_taken_d   = cond_true && !tout_q;
        err_cond_d    = (cond_q == CondRsvd);
        err_timeout_d = tout_q;
        pc_target_d   = target_q;
        state_d       = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Flush aborts whatever is in flight, including a result about to be registered.
    if (flush) begin
      state_d       = StIdle;
      timer_d       = '0;
      res_valid_d   = 1'b0;
      res_taken_d   = 1'b0;
      err_cond_d    = 1'b0;
      err_timeout_d = 1'b0;
      pc_target_d   = pc_target_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      pend_q        <= '0;
      cond_q        <= 4'd0;
      target_q      <= '0;
      tout_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_taken_q   <= 1'b0;
      err_cond_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      pc_target_q   <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      pend_q        <= pend_d;
      cond_q        <= cond_d;
      target_q      <= target_d;
      tout_q        <= tout_d;
      res_valid_q   <= res_valid_d;
      res_taken_q   <= res_taken_d;
      err_cond_q    <= err_cond_d;
      err_timeout_q <= err_timeout_d;
      pc_target_q   <= pc_target_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_taken   = res_taken_q;
  assign pc_load     = res_valid_q & res_taken_q;
  assign flush_req   = res_valid_q & res_taken_q;
  assign pc_target   = pc_target_q;
  assign err_cond    = err_cond_q;
  assign err_timeout = err_timeout_q;

endmodule
